// File: rtl/seq_divider_64by32.sv
// Iterative restoring divider: unsigned DIVIDEND_W / DIVISOR_W, one quotient bit per clock,
// valid/ready handshakes on operand and result sides.
module seq_divider_64by32 #(
    parameter int unsigned DIVIDEND_W = 64,
    parameter int unsigned DIVISOR_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  g_in_valid,
    output logic                  g_in_ready,
    input  logic [DIVIDEND_W-1:0] g_InDividend,
    input  logic [DIVISOR_W-1:0]  g_InDivisor,
    output logic                  g_out_valid,
    input  logic                  g_out_ready,
    output logic [DIVIDEND_W-1:0] g_outQ,
    output logic [DIVISOR_W-1:0]  g_outR,
    output logic                  g_out_dbz
);

    localparam int unsigned REM_W   = DIVISOR_W + 1;
    localparam int unsigned TRIAL_W = DIVISOR_W + 2;
    localparam int unsigned CNT_W   = $clog2(DIVIDEND_W + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [REM_W-1:0]        rem;
    logic [DIVIDEND_W-1:0]   quo;
    logic [DIVISOR_W-1:0]    dsr;

    logic [TRIAL_W-1:0]      trial;
    logic [TRIAL_W-1:0]      dsr_ext;
    logic                    sub_ok;
    logic [REM_W-1:0]        rem_next;
    logic [DIVIDEND_W-1:0]   quo_next;

    // One restoring step: shift {rem, quo} left, trial-subtract the divisor.
    always_comb begin
        trial    = {rem, quo[DIVIDEND_W-1]};
        dsr_ext  = TRIAL_W'(dsr);
        sub_ok   = (trial >= dsr_ext);
        rem_next = sub_ok ? REM_W'(trial - dsr_ext) : REM_W'(trial);
        quo_next = {quo[DIVIDEND_W-2:0], sub_ok};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            dsr         <= '0;
            g_in_ready  <= 1'b1;
            g_out_valid <= 1'b0;
            g_outQ      <= '0;
            g_outR      <= '0;
            g_out_dbz   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (g_in_valid) begin
                        quo        <= g_InDividend;
                        dsr        <= g_InDivisor;
                        rem        <= '0;
                        cnt        <= CNT_W'(DIVIDEND_W);
                        g_in_ready <= 1'b0;
                        // Zero divisor short-circuits straight to a flagged result.
                        if (g_InDivisor == '0) begin
                            g_outQ      <= '1;
                            g_outR      <= g_InDividend[DIVISOR_W-1:0];
                            g_out_dbz   <= 1'b1;
                            g_out_valid <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        g_outQ      <= quo_next;
                        g_outR      <= rem_next[DIVISOR_W-1:0];
                        g_out_dbz   <= 1'b0;
                        g_out_valid <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (g_out_ready) begin
                        g_out_valid <= 1'b0;
                        g_in_ready  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_64by32.sv
// Directed and randomized checks of seq_divider_64by32 against a scoreboard of / and % results.
module tb_seq_divider_64by32;

    logic        clk = 1'b0;
    logic        rst;
    logic        g_in_valid;
    logic        g_in_ready;
    logic [63:0] g_InDividend;
    logic [31:0] g_InDivisor;
    logic        g_out_valid;
    logic        g_out_ready;
    logic [63:0] g_outQ;
    logic [31:0] g_outR;
    logic        g_out_dbz;

    typedef struct {
        logic [63:0] a;
        logic [31:0] b;
        logic [63:0] q;
        logic [31:0] r;
        logic        dbz;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;
    int   lat;
    logic [63:0] hold_q;
    logic [31:0] hold_r;
    logic [95:0] prod;

    seq_divider_64by32 dut (
        .clk          (clk),
        .rst          (rst),
        .g_in_valid   (g_in_valid),
        .g_in_ready   (g_in_ready),
        .g_InDividend (g_InDividend),
        .g_InDivisor  (g_InDivisor),
        .g_out_valid  (g_out_valid),
        .g_out_ready  (g_out_ready),
        .g_outQ       (g_outQ),
        .g_outR       (g_outR),
        .g_out_dbz    (g_out_dbz)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Present operands until accepted, then push the reference result.
    task automatic send(input logic [63:0] a, input logic [31:0] b);
        exp_t x;
        int n;
        g_InDividend = a;
        g_InDivisor  = b;
        g_in_valid   = 1'b1;
        n = 0;
        while (!g_in_ready && n < 200) begin
            tick();
            n++;
        end
        chk("accept_timeout", 64'(n < 200), 64'd1);
        tick();
        g_in_valid   = 1'b0;
        g_InDividend = {$urandom, $urandom};
        g_InDivisor  = $urandom;
        x.a = a;
        x.b = b;
        if (b == 32'd0) begin
            x.q = '1;
            x.r = a[31:0];
            x.dbz = 1'b1;
        end else begin
            x.q = a / {32'd0, b};
            x.r = 32'(a % {32'd0, b});
            x.dbz = 1'b0;
        end
        exp_q.push_back(x);
    endtask

    task automatic wait_out(output int cycles);
        cycles = 0;
        while (!g_out_valid && cycles < 200) begin
            tick();
            cycles++;
        end
        chk("result_timeout", 64'(g_out_valid), 64'd1);
    endtask

    task automatic compare_pop(input string tag);
        exp_t x;
        if (exp_q.size() == 0) begin
            chk({tag, "_unexpected"}, 64'd1, 64'd0);
        end else begin
            x = exp_q.pop_front();
            chk({tag, "_q"}, g_outQ, x.q);
            chk({tag, "_r"}, 64'(g_outR), 64'(x.r));
            chk({tag, "_dbz"}, 64'(g_out_dbz), 64'(x.dbz));
            if (x.b != 32'd0) begin
                prod = 96'(g_outQ) * 96'(x.b) + 96'(g_outR);
                chk({tag, "_ident"}, 64'(prod == 96'(x.a)), 64'd1);
                chk({tag, "_rlt"}, 64'(g_outR < x.b), 64'd1);
            end
        end
    endtask

    task automatic release_out(input string tag);
        g_out_ready = 1'b1;
        tick();
        g_out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 64'(g_out_valid), 64'd0);
        chk({tag, "_in_ready"}, 64'(g_in_ready), 64'd1);
    endtask

    initial begin
        rst          = 1'b1;
        g_in_valid   = 1'b0;
        g_out_ready  = 1'b0;
        g_InDividend = '0;
        g_InDivisor  = '0;
        #12;
        chk("rst_in_ready", 64'(g_in_ready), 64'd1);
        chk("rst_out_valid", 64'(g_out_valid), 64'd0);
        chk("rst_q", g_outQ, 64'd0);
        chk("rst_r", 64'(g_outR), 64'd0);
        chk("rst_dbz", 64'(g_out_dbz), 64'd0);
        rst = 1'b0;
        tick();

        // Basic 100/7 with 64-cycle latency
        send(64'd100, 32'd7);
        wait_out(lat);
        chk("basic_latency", 64'(lat), 64'd64);
        chk("basic_q_const", g_outQ, 64'd14);
        chk("basic_r_const", 64'(g_outR), 64'd2);
        compare_pop("basic");
        release_out("basic");

        send(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF);
        wait_out(lat);
        chk("max_q_const", g_outQ, 64'h0000_0001_0000_0001);
        chk("max_r_const", 64'(g_outR), 64'd0);
        compare_pop("max");
        release_out("max");

        send(64'd5, 32'hFFFF_FFFF);
        wait_out(lat);
        chk("small_q_const", g_outQ, 64'd0);
        chk("small_r_const", 64'(g_outR), 64'd5);
        compare_pop("small");
        release_out("small");

        // Divide by zero is valid right after the accept edge
        send(64'h1234_5678_9ABC_DEF0, 32'd0);
        wait_out(lat);
        chk("dbz_latency", 64'(lat), 64'd0);
        chk("dbz_q_const", g_outQ, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("dbz_r_const", 64'(g_outR), 64'h9ABC_DEF0);
        compare_pop("dbz");
        release_out("dbz");

        // Back-pressure: result held for 20 cycles
        send(64'hDEAD_BEEF_0123_4567, 32'h0001_0003);
        wait_out(lat);
        hold_q = g_outQ;
        hold_r = g_outR;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_valid", 64'(g_out_valid), 64'd1);
            chk("bp_in_ready", 64'(g_in_ready), 64'd0);
            chk("bp_q_stable", g_outQ, hold_q);
            chk("bp_r_stable", 64'(g_outR), 64'(hold_r));
        end
        compare_pop("bp");
        release_out("bp");
        chk("idle_keeps_q", g_outQ, hold_q);

        // Asynchronous reset 30 cycles into CALC
        send(64'h0F0F_0F0F_0F0F_0F0F, 32'd12345);
        for (int i = 0; i < 30; i++) tick();
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 64'(g_in_ready), 64'd1);
        chk("mid_rst_out_valid", 64'(g_out_valid), 64'd0);
        chk("mid_rst_q", g_outQ, 64'd0);
        chk("mid_rst_r", 64'(g_outR), 64'd0);
        chk("mid_rst_dbz", 64'(g_out_dbz), 64'd0);
        void'(exp_q.pop_back());
        tick();
        tick();
        #2;
        rst = 1'b0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (g_out_valid) chk("spurious_valid", 64'(g_out_valid), 64'd0);
        end
        send(64'd1000, 32'd10);
        wait_out(lat);
        chk("post_rst_latency", 64'(lat), 64'd64);
        chk("post_rst_q_const", g_outQ, 64'd100);
        chk("post_rst_r_const", 64'(g_outR), 64'd0);
        compare_pop("post_rst");
        release_out("post_rst");

        // Randomized operands with valid/ready stalls
        for (int k = 0; k < 300; k++) begin
            logic [63:0] a;
            logic [31:0] b;
            int mode;
            int n;
            mode = int'($urandom_range(0, 5));
            a = {$urandom, $urandom};
            case (mode)
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                3: a = 64'($urandom);
                default: b = $urandom;
            endcase
            if (mode == 3) b = $urandom | 32'd1;
            if (mode == 4 && b == 32'd0) b = 32'd1;
            n = int'($urandom_range(0, 3));
            for (int i = 0; i < n; i++) tick();
            send(a, b);
            wait_out(lat);
            n = int'($urandom_range(0, 3));
            for (int i = 0; i < n; i++) tick();
            compare_pop("rnd");
            g_out_ready = 1'b1;
            tick();
            g_out_ready = 1'b0;
        end
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
